// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB3 requester bridge. One command is accepted on the cmd_* valid/ready port.
// It runs as a SETUP/ACCESS transfer on the APB bus, and the result is returned
// on the rsp_* port. Only one transfer is outstanding at a time. A watchdog
// aborts an ACCESS phase that waits too long for pready.
//
// Handshake semantics (both ports): a transfer happens on a rising pclk edge
// where valid & ready are both 1. A valid source holds valid and its payload
// stable until that edge. Ready may depend combinationally on state but never
// on the partner's valid.
//
// Ports
//   pclk, presetn            clock; synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready      response handshake; rsp_valid held until taken
//   rsp_rdata                read data (0 for writes and timeouts)
//   rsp_slverr               pslverr at completion, or 1 on timeout
//   rsp_timeout              transfer aborted by the watchdog
//   psel/penable/pwrite      APB control
//   paddr/pwdata             APB address / write data
//   prdata/pready/pslverr    APB slave response
//   state_dbg                current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [WIDTH-1:0]      pwdata,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q;
  logic             accept;
  logic             complete;
  logic             abort;
  logic             wd_expired;

  // rsp_ready deliberately does not feed cmd_ready: a new command is only
  // taken once the previous response has actually left.
  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign state_dbg = state_q;

  // The counter reads 0 in the first ACCESS cycle, so reaching TIMEOUT-1
  // means TIMEOUT ACCESS cycles have elapsed including the current one.
  assign wd_expired = (TIMEOUT > 0) && (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    psel     = 1'b0;
    penable  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        psel    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready wins over an expiring watchdog in the same cycle.
        if (pready) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      wd_cnt_q    <= '0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_SETUP) begin
        wd_cnt_q <= '0;
      end else if (state_q == ST_ACCESS) begin
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end

      // Bus payload is captured once at accept and then left alone, which
      // keeps it stable through ACCESS and parked in IDLE.
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end

      if (complete) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
